// File: rtl/scompliment_pkg.sv
// Shared definitions for the serial two's-complement link: state encoding and default word width.
package scompliment_pkg;

    localparam int unsigned WIDTH_DEFAULT = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/scompliment_bitcell.sv
// Serial two's-complement bit cell: copy bits up to and including the first 1, invert after it.
module scompliment_bitcell (
    input  logic clk,
    input  logic set,
    input  logic clr_first,
    input  logic en,
    input  logic sin,
    output logic b
);

    logic seen_one_q;
    logic seen_eff;

    // A word-start bit must not see the previous word's history.
    assign seen_eff = clr_first ? 1'b0 : seen_one_q;
    assign b        = seen_eff ? ~sin : sin;

    always_ff @(posedge clk) begin
        if (set) begin
            seen_one_q <= 1'b0;
        end else if (en) begin
            seen_one_q <= seen_eff | sin;
        end
    end

endmodule

// File: rtl/scompliment_rx.sv
// Receive end of the serial two's-complement link: re-complements the LSB-first stream and
// deserialises it into a parallel word with a one-cycle valid pulse.
module scompliment_rx
    import scompliment_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             set,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             sin_first,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             frame_err
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // Only WIDTH-1 bits are stored; the last bit goes straight into dout.
    logic [WIDTH-2:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             accept;
    logic             b;
    logic [WIDTH-1:0] shifted;

    assign accept  = sin_valid & ((state_q == ST_SHIFT) | sin_first);
    assign shifted = {b, shreg_q};

    scompliment_bitcell u_bitcell (
        .clk       (clk),
        .set       (set),
        .clr_first (sin_first),
        .en        (accept),
        .sin       (sin),
        .b         (b)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shreg_d      = shreg_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sin_valid && sin_first) begin
                    shreg_d = shifted[WIDTH-1:1];
                    cnt_d   = CNT_W'(1);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (sin_valid) begin
                    shreg_d = shifted[WIDTH-1:1];
                    if (sin_first) begin
                        frame_err_d = 1'b1;
                        cnt_d       = CNT_W'(1);
                    end else if (cnt_q == LAST_CNT) begin
                        dout_d       = shifted;
                        dout_valid_d = 1'b1;
                        cnt_d        = '0;
                        state_d      = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (set) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            shreg_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shreg_q      <= shreg_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_scompliment_rx.sv
// Randomised scoreboard bench for scompliment_rx: driver models the link, monitor checks words.
module tb_scompliment_rx;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         set = 1'b1;
    logic         sin = 1'b0;
    logic         sin_valid = 1'b0;
    logic         sin_first = 1'b0;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         busy;
    logic         frame_err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_dout = '0;
    logic         mon_on = 1'b0;
    logic         rx_bits[$];  // code bits of the word currently being received

    scompliment_rx #(.WIDTH(W)) dut (
        .clk        (clk),
        .set        (set),
        .sin        (sin),
        .sin_valid  (sin_valid),
        .sin_first  (sin_first),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    endtask

    // One clock cycle of link activity, predicted from the word-level rules.
    task automatic cyc(input logic v, input logic f, input logic s);
        logic         exp_fe;
        logic [W-1:0] code;
        exp_fe = 1'b0;
        if (v && f) begin
            exp_fe = (rx_bits.size() != 0);
            rx_bits.delete();
            rx_bits.push_back(s);
        end else if (v && rx_bits.size() != 0) begin
            rx_bits.push_back(s);
        end
        if (rx_bits.size() == W) begin
            code = '0;
            foreach (rx_bits[i]) code[i] = rx_bits[i];
            exp_q.push_back(W'(-code));  // two's complement of the received code
            rx_bits.delete();
        end
        sin_valid = v;
        sin_first = f;
        sin       = s;
        @(posedge clk);
        #1;
        chk("frame_err", 32'(frame_err), 32'(exp_fe));
        chk("busy", 32'(busy), 32'(rx_bits.size() != 0));
    endtask

    task automatic do_reset();
        set = 1'b1;
        sin_valid = 1'($urandom);
        sin_first = 1'($urandom);
        sin = 1'($urandom);
        @(posedge clk);
        #1;
        set = 1'b0;
        rx_bits.delete();
        exp_dout = '0;
        mon_on = 1'b1;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_dout", 32'(dout), 32'(0));
        chk("rst_frame_err", 32'(frame_err), 32'(0));
        chk("rst_dout_valid", 32'(dout_valid), 32'(0));
    endtask

    // Transmit word w as its two's complement, LSB first, with optional random stalls.
    task automatic send_word(input logic [W-1:0] w, input int stall_pct);
        logic [W-1:0] code;
        code = -w;
        for (int i = 0; i < W; i++) begin
            while ($urandom_range(0, 99) < stall_pct) cyc(1'b0, 1'($urandom), 1'($urandom));
            cyc(1'b1, (i == 0), code[i]);
        end
    endtask

    task automatic send_partial(input int k);
        for (int i = 0; i < k; i++) cyc(1'b1, (i == 0), 1'($urandom));
    endtask

    always @(negedge clk) begin
        if (mon_on && !set) begin
            if (dout_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_dout_valid", 32'(1), 32'(0));
                end else begin
                    exp_dout = exp_q.pop_front();
                    chk("dout_word", 32'(dout), 32'(exp_dout));
                end
            end else begin
                chk("dout_hold", 32'(dout), 32'(exp_dout));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        @(posedge clk);
        do_reset();
        send_word(4'b1010, 0);
        cyc(1'b0, 1'b0, 1'b0);
        send_word(4'b1000, 0);          // most-negative code
        send_word(4'b0001, 0);          // all-ones stream, back to back
        send_word(4'b0000, 0);          // all-zero stream
        // stall in the middle of a word
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        repeat (3) cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        // truncated word followed by a fresh one
        send_partial(2);
        send_word(4'b1111, 0);
        // reset mid-word, then a full word
        send_partial(2);
        do_reset();
        send_word(4'b1110, 0);
        // stray bits while idle
        repeat (4) cyc(1'b1, 1'b0, 1'($urandom));
        cyc(1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                send_partial($urandom_range(1, W - 1));
                do_reset();
            end else if (r == 1) begin
                send_partial($urandom_range(1, W - 1));
            end else if (r == 2) begin
                repeat ($urandom_range(1, 3)) cyc(1'($urandom), 1'b0, 1'($urandom));
            end else begin
                send_word(W'($urandom), (r > 6) ? 30 : 0);
            end
        end
        sin_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
